// File: rtl/r5p_bus_arb_if.sv
// R5P load/store bus bundle, N ports wide.
// A requester drives vld/wen/adr/ben/wdt and receives rdt/rdy.
// Port i occupies bits [i*W +: W] of each field of width W.
//   master : requester side (drives the request, receives the response)
//   slave  : subordinate side (receives the request, drives the response)
interface r5p_bus_arb_if #(
  parameter int N  = 1,
  parameter int AW = 22,
  parameter int DW = 32,
  parameter int BW = DW/8
);
  logic [N-1:0]    vld;
  logic [N-1:0]    wen;
  logic [N*AW-1:0] adr;
  logic [N*BW-1:0] ben;
  logic [N*DW-1:0] wdt;
  logic [N*DW-1:0] rdt;
  logic [N-1:0]    rdy;

  modport master (output vld, wen, adr, ben, wdt, input rdt, rdy);
  modport slave  (input vld, wen, adr, ben, wdt, output rdt, rdy);
endinterface

// File: rtl/r5p_bus_arb.sv
// Arbiter sharing one R5P subordinate port between RN requesters.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   m        : RN requester ports (m.vld/wen/adr/ben/wdt in, m.rdt/rdy out)
//   s        : single subordinate port (s.vld/wen/adr/ben/wdt out, s.rdt/rdy in)
// Grant is combinational (round-robin from ptr, or lowest index for "FIX").
// A request that is presented but stalled stays locked until accepted.
// Read data returns LAT cycles after acceptance and is steered back to
// the requester that issued the read.
module r5p_bus_arb #(
  parameter int    AW   = 22,
  parameter int    DW   = 32,
  parameter int    BW   = DW/8,
  parameter int    RN   = 2,
  parameter int    LAT  = 1,
  parameter string MODE = "RR"
)(
  input  logic           clk,
  input  logic           rst,
  r5p_bus_arb_if.slave   m,
  r5p_bus_arb_if.master  s
);
  localparam int IW  = (RN > 1) ? $clog2(RN) : 1;
  localparam bit FIX = (MODE == "FIX");

  logic [IW-1:0] ptr_reg, ptr_next, ptr_eff;
  logic [IW-1:0] lid_reg, lid_next;
  logic          lck_reg, lck_next, lck_eff;
  logic [IW-1:0] gid, cand;
  logic          found, any_vld, xfer;
  logic [RN-1:0] gnt;

  // Response pipeline: one {val, id} entry per latency stage.
  logic [LAT-1:0] val_reg;
  logic [IW-1:0]  id_reg [LAT];

  // While rst is high the outputs must already look like the reset state,
  // so the stored pointer and lock are masked before they reach the grant.
  assign ptr_eff = rst ? '0 : ptr_reg;
  assign lck_eff = lck_reg & ~rst;
  assign any_vld = |m.vld;

  // A locked requester that drops vld loses the lock in the same cycle,
  // so the subordinate never sees the fields of an idle requester.
  always_comb begin
    gid   = '0;
    found = 1'b0;
    cand  = '0;
    if (lck_eff && m.vld[lid_reg]) begin
      gid   = lid_reg;
      found = 1'b1;
    end else begin
      for (int k = 0; k < RN; k++) begin
        cand = FIX ? IW'(k) : IW'((int'(ptr_eff) + k) % RN);
        if (!found && m.vld[cand]) begin
          gid   = cand;
          found = 1'b1;
        end
      end
    end
  end

  assign xfer  = found & s.rdy;
  assign s.vld = any_vld;
  assign s.wen = found & m.wen[gid];
  assign s.adr = found ? m.adr[gid*AW +: AW] : '0;
  assign s.ben = found ? m.ben[gid*BW +: BW] : '0;
  assign s.wdt = found ? m.wdt[gid*DW +: DW] : '0;
  assign m.rdy = s.rdy ? gnt : '0;

  // A stalled request locks the current grant; acceptance or an empty
  // request set releases it.
  always_comb begin
    lck_next = found & ~s.rdy;
    lid_next = gid;
    ptr_next = ptr_eff;
    if (!FIX && xfer)
      ptr_next = (gid == IW'(RN-1)) ? '0 : gid + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
      lck_reg <= 1'b0;
      lid_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
      lck_reg <= lck_next;
      lid_reg <= lid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_reg <= '0;
      for (int k = 0; k < LAT; k++) id_reg[k] <= '0;
    end else begin
      val_reg[0] <= xfer & ~s.wen;
      id_reg[0]  <= gid;
      for (int k = 1; k < LAT; k++) begin
        val_reg[k] <= val_reg[k-1];
        id_reg[k]  <= id_reg[k-1];
      end
    end
  end

  for (genvar gi = 0; gi < RN; gi++) begin : g_port
    assign gnt[gi] = found && (gid == IW'(gi));
    assign m.rdt[gi*DW +: DW] =
      (!rst && val_reg[LAT-1] && (id_reg[LAT-1] == IW'(gi))) ? s.rdt : '0;
  end
endmodule
